// File: rtl/dmem_pkg.sv
// Shared types and address decode for the data-memory responder.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RAM,
        MMIO,
        BAD
    } addr_kind_t;

    // Misaligned addresses are BAD, including a misaligned hit near the MMIO word.
    function automatic addr_kind_t classify_addr(
        input logic [31:0] addr,
        input logic [31:0] ram_bytes,
        input logic [31:0] mmio_base
    );
        if (addr[1:0] != 2'b00) return BAD;
        if (addr == mmio_base)  return MMIO;
        if (addr < ram_bytes)   return RAM;
        return BAD;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with byte-lane write enables and synchronous read.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read data only moves when enabled, so it stays stable for the whole response.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data-memory port: wait states, RAM access, tohost MMIO word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state;
    logic [3:0]  count;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    addr_kind_t  rsp_kind;
    logic        rsp_write;
    logic [31:0] tohost;

    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    addr_kind_t  acc_kind;
    logic        do_access;
    logic        bank_en;
    logic [3:0]  bank_we;
    logic [31:0] bank_rdata;

    // With zero wait states the access uses the live request instead of the latch.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

    assign acc_kind  = classify_addr(acc_addr, RAM_BYTES, MMIO_BASE);
    assign do_access = !rst && (((state == IDLE) && req_valid && (LATENCY == 0)) ||
                                ((state == WAIT) && (count == 4'd0)));
    assign bank_en   = do_access && (acc_kind == RAM);
    assign bank_we   = acc_write ? acc_wstrb : 4'b0000;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_wstrb    <= 4'd0;
            rsp_kind     <= RAM;
            rsp_write    <= 1'b0;
            tohost       <= 32'd0;
            tohost_valid <= 1'b0;
        end else begin
            tohost_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        count     <= CNT_INIT;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) state <= RESP;
                    else               count <= count - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Response attributes are captured once, so a stalled RESP never re-executes.
            if (do_access) begin
                rsp_kind  <= acc_kind;
                rsp_write <= acc_write;
                if (acc_kind == MMIO && acc_write) begin
                    for (int i = 0; i < 4; i++) begin
                        if (acc_wstrb[i]) tohost[8*i +: 8] <= acc_wdata[8*i +: 8];
                    end
                    tohost_valid <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (state == IDLE) && !rst;
    assign rsp_valid   = (state == RESP);
    assign rsp_error   = rsp_valid && (rsp_kind == BAD);
    assign tohost_data = tohost;

    always_comb begin
        rsp_rdata = 32'd0;
        if (rsp_valid && !rsp_write) begin
            if (rsp_kind == RAM)       rsp_rdata = bank_rdata;
            else if (rsp_kind == MMIO) rsp_rdata = tohost;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=2 and hand-computed expectations.
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    int vectors    = 0;
    int miscompares = 0;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .MMIO_BASE   (MMIO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response; lat counts cycles from acceptance to the first rsp_valid.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int stall,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int pulses, output logic pulse_first, output logic hold_ok);
        int guard;
        rd = '0; er = 1'b0; lat = 0; pulses = 0; pulse_first = 1'b0; hold_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (tohost_valid) pulses++;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata;
        er = rsp_error;
        pulse_first = tohost_valid;
        repeat (stall) begin
            @(negedge clk);
            if (tohost_valid) pulses++;
            if (!rsp_valid || req_ready || rsp_rdata !== rd || rsp_error !== er) hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        if (tohost_valid) pulses++;
        if (rsp_valid || !req_ready) hold_ok = 1'b0;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    logic        pf;
    logic        hold;
    int          guard;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_tohost_valid", 32'(tohost_valid), 32'd0);
        check("rst_tohost_data", tohost_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Full-word store then load
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, pulses, pf, hold);
        check("st10_lat", 32'(lat), 32'd3);
        check("st10_err", 32'(er), 32'd0);
        check("st10_rdata", rd, 32'd0);
        check("st10_hold", 32'(hold), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld10_lat", 32'(lat), 32'd3);
        check("ld10_rdata", rd, 32'hDEADBEEF);
        check("ld10_err", 32'(er), 32'd0);

        // Byte-lane merge
        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat, pulses, pf, hold);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld10_byte0", rd, 32'hDEADBEAA);

        // Misaligned and unmapped
        txn(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld12_err", 32'(er), 32'd1);
        check("ld12_rdata", rd, 32'd0);
        txn(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, pulses, pf, hold);
        check("st13_err", 32'(er), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld10_after_bad", rd, 32'hDEADBEAA);
        txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld1000_err", 32'(er), 32'd1);
        check("ld1000_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("st0_err", 32'(er), 32'd0);

        // Middle lanes, then a no-op strobe
        txn(1'b1, 32'h10, 32'h00BBCC00, 4'b0110, 0, rd, er, lat, pulses, pf, hold);
        txn(1'b1, 32'h10, 32'h77777777, 4'b0000, 0, rd, er, lat, pulses, pf, hold);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("ld10_lanes12", rd, 32'hDEBBCCAA);

        // tohost MMIO
        txn(1'b1, MMIO, 32'h1, 4'hF, 0, rd, er, lat, pulses, pf, hold);
        check("mmio_st_pulses", 32'(pulses), 32'd1);
        check("mmio_st_pulse_first", 32'(pf), 32'd1);
        check("mmio_st_err", 32'(er), 32'd0);
        check("mmio_tohost", tohost_data, 32'h1);
        txn(1'b0, MMIO, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("mmio_ld_rdata", rd, 32'h1);
        check("mmio_ld_pulses", 32'(pulses), 32'd0);
        txn(1'b1, MMIO, 32'h00005500, 4'b0010, 0, rd, er, lat, pulses, pf, hold);
        check("mmio_lane1", tohost_data, 32'h00005501);

        // Response stall on a store
        txn(1'b1, 32'h30, 32'h12345678, 4'hF, 5, rd, er, lat, pulses, pf, hold);
        check("stall_lat", 32'(lat), 32'd3);
        check("stall_hold", 32'(hold), 32'd1);
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("stall_ld30", rd, 32'h12345678);

        // Reset in WAIT drops the pending store
        txn(1'b1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat, pulses, pf, hold);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h22222222; req_wstrb = 4'hF;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rstw_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_req_ready_in_rst", 32'(req_ready), 32'd0);
        check("rstw_tohost_cleared", tohost_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_idle", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, pulses, pf, hold);
        check("rstw_ld20", rd, 32'h11111111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
